// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and sizing: the broadcast packet seen by the ROB, the RS and this arbiter.
// Widths are fixed here so every consumer agrees on the packet layout.
package cdb_arbiter_pkg;

  localparam int NUM_FU        = 4;
  localparam int XLEN          = 32;
  localparam int ROB_ADDR_LEN  = 4;
  localparam int PREG_ADDR_LEN = 6;
  localparam int FU_IDX_W      = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef logic [FU_IDX_W-1:0] fu_idx_t;

  typedef struct packed {
    logic                     valid;
    logic [ROB_ADDR_LEN-1:0]  rob_tag;
    logic [PREG_ADDR_LEN-1:0] preg;
    logic [XLEN-1:0]          result;
  } cdb_packet_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU result ports and CDB broadcast bundle; the producer side (FUs/bench) uses master, the arbiter uses slave.
// Per-FU fields are flat vectors, FU i occupying slice [i*W +: W].
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic [NUM_FU-1:0]               fu_valid;
  logic [NUM_FU*ROB_ADDR_LEN-1:0]  fu_rob_tag;
  logic [NUM_FU*PREG_ADDR_LEN-1:0] fu_preg;
  logic [NUM_FU*XLEN-1:0]          fu_result;
  logic [NUM_FU-1:0]               fu_ready;

  logic                            cdb_valid;
  logic [ROB_ADDR_LEN-1:0]         cdb_rob_tag;
  logic [PREG_ADDR_LEN-1:0]        cdb_preg;
  logic [XLEN-1:0]                 cdb_result;

  modport master (
    output fu_valid, fu_rob_tag, fu_preg, fu_result,
    input  fu_ready, cdb_valid, cdb_rob_tag, cdb_preg, cdb_result
  );

  modport slave (
    input  fu_valid, fu_rob_tag, fu_preg, fu_result,
    output fu_ready, cdb_valid, cdb_rob_tag, cdb_preg, cdb_result
  );

endinterface

// File: rtl/cdb_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot grant searched from rr_ptr, wrapping modulo NUM_REQ.
// rr_ptr moves past the winner when advance is set; clear returns it to 0 and overrides advance.
module cdb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic               clear,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner,
  output logic               grant_vld
);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] idx;

  // First requester at or after rr_ptr wins; explicit modulo keeps non-power-of-2 counts correct.
  always_comb begin
    grant     = '0;
    winner    = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_vld && req[idx]) begin
        grant_vld  = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (clear) begin
      rr_ptr_d = '0;
    end else if (advance && grant_vld) begin
      rr_ptr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(grant));

endmodule

// File: rtl/cdb_arbiter.sv
// One-entry hold per FU feeding a round-robin-arbitrated, registered CDB; a result accepted at edge k
// broadcasts at edge k+1 at the earliest. fu_ready[i] = hold empty or being granted; flush squashes all.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);

  cdb_packet_t        hold_q [NUM_FU];
  cdb_packet_t        hold_d [NUM_FU];
  cdb_packet_t        cdb_q, cdb_d;
  logic [NUM_FU-1:0]  hold_vld;
  logic [NUM_FU-1:0]  grant;
  logic [NUM_FU-1:0]  fu_ready;
  fu_idx_t            winner;
  logic               grant_vld;

  always_comb begin
    hold_vld = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      hold_vld[i] = hold_q[i].valid;
    end
  end

  cdb_rr_arbiter #(
    .NUM_REQ (NUM_FU),
    .IDX_W   (FU_IDX_W)
  ) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (hold_vld),
    .advance   (!flush),
    .clear     (flush),
    .grant     (grant),
    .winner    (winner),
    .grant_vld (grant_vld)
  );

  // A granted hold frees this edge, so its FU may refill it in the same edge.
  assign fu_ready = ~hold_vld | grant;

  always_comb begin
    hold_d      = hold_q;
    cdb_d       = cdb_q;
    cdb_d.valid = 1'b0;
    if (grant_vld) begin
      cdb_d = hold_q[winner];
    end
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        hold_d[i].valid = 1'b0;
      end
      if (bus.fu_valid[i] && fu_ready[i]) begin
        hold_d[i].valid   = 1'b1;
        hold_d[i].rob_tag = bus.fu_rob_tag[i*ROB_ADDR_LEN +: ROB_ADDR_LEN];
        hold_d[i].preg    = bus.fu_preg[i*PREG_ADDR_LEN +: PREG_ADDR_LEN];
        hold_d[i].result  = bus.fu_result[i*XLEN +: XLEN];
      end
    end
    // Squash wins over both the pending broadcast and any same-edge accepts.
    if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        hold_d[i].valid = 1'b0;
      end
      cdb_d       = cdb_q;
      cdb_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        hold_q[i] <= '0;
      end
      cdb_q <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        hold_q[i] <= hold_d[i];
      end
      cdb_q <= cdb_d;
    end
  end

  assign bus.fu_ready    = fu_ready;
  assign bus.cdb_valid   = cdb_q.valid;
  assign bus.cdb_rob_tag = cdb_q.rob_tag;
  assign bus.cdb_preg    = cdb_q.preg;
  assign bus.cdb_result  = cdb_q.result;

  a_flush_kills_cdb: assert property (@(posedge clk) disable iff (!reset) flush |=> !bus.cdb_valid);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single FU, contention, fairness, back-to-back and flush,
// with a CDB monitor collecting broadcast tags for order/uniqueness checks.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  cdb_arbiter_if bus();

  cdb_arbiter dut (
    .clk   (clk),
    .reset (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [ROB_ADDR_LEN-1:0] seen [$];
  logic [ROB_ADDR_LEN-1:0] exp_q [$];
  logic [3:0]              tab [NUM_FU][8];
  int                      cnt [NUM_FU];
  int                      pos [NUM_FU];

  always @(negedge clk) begin
    if (rst_n && bus.cdb_valid) seen.push_back(bus.cdb_rob_tag);
  end

  function automatic logic [PREG_ADDR_LEN-1:0] pg_of(input logic [3:0] t);
    return {2'b10, t};
  endfunction

  function automatic logic [XLEN-1:0] res_of(input logic [3:0] t);
    return 32'hC0DE_0000 | {28'h0, t};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_fu();
    bus.fu_valid   = '0;
    bus.fu_rob_tag = '0;
    bus.fu_preg    = '0;
    bus.fu_result  = '0;
  endtask

  task automatic drive_fu(input int i, input logic [3:0] t);
    bus.fu_valid[i] = 1'b1;
    bus.fu_rob_tag[i*ROB_ADDR_LEN +: ROB_ADDR_LEN] = t;
    bus.fu_preg[i*PREG_ADDR_LEN +: PREG_ADDR_LEN]  = pg_of(t);
    bus.fu_result[i*XLEN +: XLEN]                  = res_of(t);
  endtask

  // Each FU offers its table in order and advances only when its offer meets fu_ready.
  task automatic run_traffic(input int ncyc);
    logic [NUM_FU-1:0] acc;
    for (int i = 0; i < NUM_FU; i++) pos[i] = 0;
    for (int c = 0; c < ncyc; c++) begin
      idle_fu();
      for (int i = 0; i < NUM_FU; i++)
        if (pos[i] < cnt[i]) drive_fu(i, tab[i][pos[i]]);
      acc = bus.fu_valid & bus.fu_ready;
      tick();
      for (int i = 0; i < NUM_FU; i++)
        if (acc[i]) pos[i]++;
    end
    idle_fu();
  endtask

  task automatic check_seen(input string name);
    check({name, "_count"}, 64'(seen.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      check($sformatf("%s_%0d", name, k), (k < seen.size()) ? 64'(seen[k]) : '1, 64'(exp_q[k]));
  endtask

  initial begin
    idle_fu();
    tick();
    tick();

    // Reset state
    check("rst_valid",  bus.cdb_valid,   0);
    check("rst_ready",  bus.fu_ready,    4'hF);
    check("rst_tag",    bus.cdb_rob_tag, 0);
    check("rst_preg",   bus.cdb_preg,    0);
    check("rst_result", bus.cdb_result,  0);
    rst_n = 1'b1;

    // Single FU: FU2 accepted at e1, visible only after e2
    seen.delete();
    bus.fu_valid[2] = 1'b1;
    bus.fu_rob_tag[2*ROB_ADDR_LEN +: ROB_ADDR_LEN] = 4'd5;
    bus.fu_preg[2*PREG_ADDR_LEN +: PREG_ADDR_LEN]  = 6'd17;
    bus.fu_result[2*XLEN +: XLEN]                  = 32'hDEADBEEF;
    tick();
    idle_fu();
    check("t2_early",  bus.cdb_valid, 0);
    check("t2_ready",  bus.fu_ready,  4'hF);
    tick();
    check("t2_valid",  bus.cdb_valid,   1);
    check("t2_tag",    bus.cdb_rob_tag, 5);
    check("t2_preg",   bus.cdb_preg,    17);
    check("t2_result", bus.cdb_result,  32'hDEADBEEF);
    tick();
    check("t2_drop",   bus.cdb_valid,   0);
    check("t2_hold",   bus.cdb_rob_tag, 5);

    // Mid-run reset with holds full
    for (int i = 0; i < NUM_FU; i++) drive_fu(i, 4'(i + 1));
    tick();
    idle_fu();
    tick();
    check("t1_busy", bus.cdb_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t1_valid", bus.cdb_valid,   0);
    check("t1_ready", bus.fu_ready,    4'hF);
    check("t1_tag",   bus.cdb_rob_tag, 0);
    tick();
    rst_n = 1'b1;
    seen.delete();
    drive_fu(0, 4'd6);
    drive_fu(3, 4'd9);
    tick();
    idle_fu();
    tick();
    check("t1_ptr0_first", bus.cdb_rob_tag, 6);
    tick();
    check("t1_second",     bus.cdb_rob_tag, 9);
    tick();
    check("t1_idle",       bus.cdb_valid, 0);
    exp_q = '{4'd6, 4'd9};
    check_seen("t1_seen");

    // Contention: all FUs at once, tags 1..4
    seen.delete();
    for (int i = 0; i < NUM_FU; i++) drive_fu(i, 4'(i + 1));
    tick();
    idle_fu();
    check("t3_ready_e1", bus.fu_ready, 4'b0001);
    tick();
    check("t3_tag_e2",   bus.cdb_rob_tag, 1);
    check("t3_ready_e2", bus.fu_ready, 4'b0011);
    tick();
    check("t3_tag_e3",   bus.cdb_rob_tag, 2);
    check("t3_ready_e3", bus.fu_ready, 4'b0111);
    tick();
    check("t3_tag_e4",   bus.cdb_rob_tag, 3);
    check("t3_ready_e4", bus.fu_ready, 4'b1111);
    tick();
    check("t3_tag_e5",   bus.cdb_rob_tag, 4);
    check("t3_preg_e5",  bus.cdb_preg,   pg_of(4'd4));
    check("t3_res_e5",   bus.cdb_result, res_of(4'd4));
    tick();
    check("t3_idle",     bus.cdb_valid, 0);
    exp_q = '{4'd1, 4'd2, 4'd3, 4'd4};
    check_seen("t3_seen");

    // Fairness: FU0 streams while FU3 also has results
    seen.delete();
    for (int i = 0; i < NUM_FU; i++) cnt[i] = 0;
    tab[0][0] = 4'd8; tab[0][1] = 4'd9; tab[0][2] = 4'd10; tab[0][3] = 4'd11; cnt[0] = 4;
    tab[3][0] = 4'd3; tab[3][1] = 4'd4; tab[3][2] = 4'd5; cnt[3] = 3;
    run_traffic(12);
    exp_q = '{4'd8, 4'd3, 4'd9, 4'd4, 4'd10, 4'd5, 4'd11};
    check_seen("t4_seen");

    // Back-to-back from FU1
    seen.delete();
    drive_fu(1, 4'd7);
    check("t5_rdy_a", bus.fu_ready[1], 1);
    tick();
    drive_fu(1, 4'd8);
    check("t5_rdy_b", bus.fu_ready[1], 1);
    check("t5_early", bus.cdb_valid, 0);
    tick();
    check("t5_tag7",  bus.cdb_rob_tag, 7);
    drive_fu(1, 4'd9);
    check("t5_rdy_c", bus.fu_ready[1], 1);
    tick();
    idle_fu();
    check("t5_tag8",  bus.cdb_rob_tag, 8);
    check("t5_v8",    bus.cdb_valid, 1);
    tick();
    check("t5_tag9",  bus.cdb_rob_tag, 9);
    check("t5_v9",    bus.cdb_valid, 1);
    tick();
    check("t5_idle",  bus.cdb_valid, 0);

    // Flush with three held results and a new FU0 result at the flush edge
    seen.delete();
    drive_fu(1, 4'd10);
    drive_fu(2, 4'd11);
    drive_fu(3, 4'd12);
    tick();
    idle_fu();
    check("t6_ready_held", bus.fu_ready, 4'b0101);
    flush = 1'b1;
    drive_fu(0, 4'd13);
    tick();
    flush = 1'b0;
    idle_fu();
    check("t6_valid", bus.cdb_valid, 0);
    check("t6_ready", bus.fu_ready,  4'hF);
    for (int c = 0; c < 4; c++) tick();
    exp_q.delete();
    check_seen("t6_none");
    drive_fu(0, 4'd14);
    drive_fu(3, 4'd15);
    tick();
    idle_fu();
    tick();
    check("t6_ptr0",   bus.cdb_rob_tag, 14);
    check("t6_preg",   bus.cdb_preg,    pg_of(4'd14));
    check("t6_result", bus.cdb_result,  res_of(4'd14));
    tick();
    check("t6_next",   bus.cdb_rob_tag, 15);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
